// File: rtl/pc_branch_unit.sv
// Program counter with branch/jump redirect, one-cycle flush pulse and saturating taken-branch counter.
// Optional macro BNE_SUPPORT_EN adds BNE (branch when zero flag is clear) to the branch decision.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_eq,
  input  logic                   branch_ne,
  input  logic                   zero,
  input  logic                   jump,
  input  logic [25:0]            jump_target,
  input  logic [31:0]            imm_ext,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   pc_src,
  output logic                   flush,
  output logic [COUNT_WIDTH-1:0] taken_count
);

  logic [31:0]            pc_q, pc_d;
  logic                   flush_q, flush_d;
  logic [COUNT_WIDTH-1:0] taken_count_q, taken_count_d;
  logic [31:0]            branch_addr_s;
  logic [31:0]            jump_addr_s;
  logic                   unused_ok;

`ifdef BNE_SUPPORT_EN
  assign unused_ok = ^imm_ext[31:30];
`else
  assign unused_ok = ^{imm_ext[31:30], branch_ne};
`endif

  // Sequential-address, target-address and branch-decision logic.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_addr_s = pc_plus4 + {imm_ext[29:0], 2'b00};
    jump_addr_s   = {pc_plus4[31:28], jump_target, 2'b00};
`ifdef BNE_SUPPORT_EN
    pc_src = (branch_eq & zero) | (branch_ne & ~zero);
`else
    pc_src = branch_eq & zero;
`endif
  end

  // Next-state selection: stall holds everything, jump outranks a taken branch.
  always_comb begin
    pc_d          = pc_q;
    flush_d       = 1'b0;
    taken_count_d = taken_count_q;
    if (stall) begin
      pc_d          = pc_q;
      flush_d       = 1'b0;
      taken_count_d = taken_count_q;
    end else if (jump) begin
      pc_d    = jump_addr_s;
      flush_d = 1'b1;
    end else if (pc_src) begin
      pc_d    = branch_addr_s;
      flush_d = 1'b1;
      if (taken_count_q != {COUNT_WIDTH{1'b1}}) begin
        taken_count_d = taken_count_q + COUNT_WIDTH'(1);
      end else begin
        taken_count_d = taken_count_q;
      end
    end else begin
      pc_d = pc_plus4;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      taken_count_q <= {COUNT_WIDTH{1'b0}};
    end else begin
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed table-driven bench for pc_branch_unit (4-bit counter instance), plus
// hand sequences for saturation, reset-during-redirect, BNE and address wrap.
module tb_pc_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef BNE_SUPPORT_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, branch_eq, branch_ne, zero, jump;
  logic [25:0] jump_target;
  logic [31:0] imm_ext;
  logic [31:0] pc, pc_plus4;
  logic        pc_src, flush;
  logic [3:0]  taken_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  pc_branch_unit #(.RESET_PC(RST_PC), .COUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .zero(zero), .jump(jump), .jump_target(jump_target),
    .imm_ext(imm_ext), .pc(pc), .pc_plus4(pc_plus4), .pc_src(pc_src),
    .flush(flush), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, beq, bne, zero, jump;
    logic [25:0] jt;
    logic [31:0] imm;
    logic        exp_src;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic st, logic be, logic bn, logic z, logic j,
                              logic [25:0] t, logic [31:0] im, logic s,
                              logic [31:0] p, logic f, logic [3:0] c);
    vec_t v;
    v.stall = st; v.beq = be; v.bne = bn; v.zero = z; v.jump = j;
    v.jt = t; v.imm = im; v.exp_src = s; v.exp_pc = p; v.exp_flush = f; v.exp_cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic be, input logic bn, input logic z,
                       input logic j, input logic [25:0] t, input logic [31:0] im);
    stall = st; branch_eq = be; branch_ne = bn; zero = z; jump = j;
    jump_target = t; imm_ext = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] cur_pc;
  logic [3:0]  exp_c;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0);

    //      st    beq   bne   z     j     jt            imm            src   pc             fl    cnt
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_0004, 1'b0, 4'd0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_0008, 1'b0, 4'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_000C, 1'b0, 4'd0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_0010, 1'b0, 4'd0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0,        32'hFFFF_FFFE, 1'b1, 32'h0040_000C, 1'b1, 4'd1);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0,        32'd5,         1'b0, 32'h0040_0010, 1'b0, 4'd1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_0014, 1'b0, 4'd1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_0018, 1'b0, 4'd1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_001C, 1'b0, 4'd1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0,        32'd0,         1'b0, 32'h0040_0020, 1'b0, 4'd1);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 26'h010_0000, 32'd7,         1'b1, 32'h0040_0000, 1'b1, 4'd1);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0,        32'd3,         1'b1, 32'h0040_0000, 1'b0, 4'd1);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0,        32'd3,         1'b1, 32'h0040_0000, 1'b0, 4'd1);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0,        32'd3,         1'b1, 32'h0040_0010, 1'b1, 4'd2);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 26'h3FF_FFFF, 32'd0,         1'b0, 32'h0040_0010, 1'b0, 4'd2);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 26'd0,        32'd4,         1'b0, 32'h0040_0014, 1'b0, 4'd2);

    // Reset state and combinational outputs right after reset.
    tick();
    reset = 1'b0;
    check("reset_pc", pc, RST_PC);
    check("reset_flush", {31'd0, flush}, 32'd0);
    check("reset_cnt", {28'd0, taken_count}, 32'd0);
    check("reset_pc_plus4", pc_plus4, 32'h0040_0004);

    cur_pc = RST_PC;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, vecs[i].beq, vecs[i].bne, vecs[i].zero, vecs[i].jump,
            vecs[i].jt, vecs[i].imm);
      #1;
      check($sformatf("v%0d_pc_plus4", i), pc_plus4, cur_pc + 32'd4);
      check($sformatf("v%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_src});
      tick();
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("v%0d_cnt", i), {28'd0, taken_count}, {28'd0, vecs[i].exp_cnt});
      cur_pc = vecs[i].exp_pc;
    end

    // Counter saturation: 17 taken branches with zero offset.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0, 32'd0);
      tick();
      exp_c = (i >= 14) ? 4'hF : 4'(i + 1);
      check($sformatf("sat%0d_cnt", i), {28'd0, taken_count}, {28'd0, exp_c});
    end
    check("sat_pc", pc, RST_PC + 32'd68);
    check("sat_flush", {31'd0, flush}, 32'd1);

    // Reset during a jump and during a stall discards the update.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 26'h3FF_FFFF, 32'd9);
    reset = 1'b1;
    tick();
    check("rst_jump_pc", pc, RST_PC);
    check("rst_jump_flush", {31'd0, flush}, 32'd0);
    check("rst_jump_cnt", {28'd0, taken_count}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0, 32'd9);
    tick();
    reset = 1'b0;
    check("rst_stall_pc", pc, RST_PC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0);
    tick();
    check("post_rst_pc", pc, 32'h0040_0004);

    // BNE at reset PC.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 26'd0, 32'd4);
    #1;
    check("bne_src", {31'd0, pc_src}, {31'd0, BNE});
    tick();
    check("bne_pc", pc, BNE ? 32'h0040_0014 : 32'h0040_0004);
    check("bne_cnt", {28'd0, taken_count}, BNE ? 32'd1 : 32'd0);

    // Branch-target overflow and pc_plus4 wrap at the top of the address space.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0, 32'h3FEF_FFFE);
    tick();
    check("wrap_branch_pc", pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0);
    #1;
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    tick();
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_flush", {31'd0, flush}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
